reg_lock_tracker: RTL and testbench
===================================

# reg_lock_tracker

Holds the architectural register lock state for the issue stage: sets locks when instructions with a destination register issue, clears them on writeback, and tracks blocking-instruction and memory-busy status. It is the state-holding counterpart of `reg_gnt_ckr`:
- `locks_o` feeds its `locks_i`.
- `mem_busy_o` feeds its `mem_busy_i`.
- Issue inputs come from the granted instruction leaving `reg_gnt_ckr`.

Register 0 is hard-wired and never locked, except by a blocking instruction.

## Interface
- `NR`, `maverickOne_pkg::NUM_REGS`: number of architectural registers (power of two).
- `NW`, `maverickOne_pkg::NUM_WB`: number of writeback ports (default 2).
- `CW`, `maverickOne_pkg::LOCK_CNT_W`: per-register in-flight writer counter width (default 2).
- `clk_i`  in  1  clock; all state updates on rising edge.
- `arst_i`  in  1  asynchronous, active-high reset.
- `issue_valid_i`  in  1  granted instruction issues this cycle.
- `issue_rd_i`  in  $clog2(NR)  destination register of issuing instruction.
- `issue_blocking_i`  in  1  issuing instruction is blocking (fence/CSR/system).
- `issue_mem_op_i`  in  1  issuing instruction is a memory operation.
- `issue_ready_o`  out  1  combinational; issue accepted this cycle if high.
- `wb_valid_i`  in  NW  per-port writeback valid.
- `wb_rd_i`  in  NW x $clog2(NR)  per-port writeback destination.
- `blk_done_i`  in  1  blocking instruction retired.
- `mem_done_i`  in  1  outstanding memory operation completed.
- `locks_o`  out  NR  register lock vector (registered).
- `blocking_o`  out  1  high while in BLOCKED state (registered).
- `mem_busy_o`  out  1  memory unit busy (registered).
- `err_o`  out  1  sticky protocol error flag (registered).

## Operation
- Each register has a counter `cnt[i]` of width CW, holding the number of in-flight writers. `cnt[0]` is held at 0.
- Issue accepted when `issue_valid_i & issue_ready_o`:
  - `issue_rd_i != 0` increments `cnt[rd]`.
  - `issue_rd_i == 0` is a no-op on the counters.
- `issue_ready_o = (state == NORMAL) & (cnt[issue_rd_i] != 2^CW-1)`.
- Writeback: each valid port with `rd != 0` decrements `cnt[rd]`.
- Simultaneous events on one register: net delta = (+1 if issue) − (number of matching wb ports). Examples:
  - issue and one wb on the same rd: counter unchanged.
  - two wb on the same rd: decrement by 2.
- Underflow (decrement past 0): counter clamps at 0 and `err_o` sets.
- `issue_valid_i` while `issue_ready_o` is low: issue is ignored and `err_o` sets.
- `locks_o[i] = (cnt[i] != 0) | (state == BLOCKED)`, computed from next-state and registered.
- FSM:
  - NORMAL → BLOCKED on an accepted issue with `issue_blocking_i`.
  - BLOCKED → NORMAL on `blk_done_i`.
  - `blk_done_i` while in NORMAL is ignored and sets `err_o`.
  - Writebacks continue to update counters while BLOCKED.
- `mem_busy`:
  - Set on an accepted issue with `issue_mem_op_i`.
  - Cleared on `mem_done_i`.
  - Set and clear in the same cycle: stays set (new operation).
- `err_o` clears only on reset.

## Timing
- Reset values, asserted asynchronously: all `cnt` = 0, `locks_o` = 0, `blocking_o` = 0, `mem_busy_o` = 0, `err_o` = 0, state = NORMAL.
- While `arst_i` is high, `issue_ready_o` = 1 and inputs are ignored.
- Reset mid-operation discards all in-flight locks.
- Latency:
  - An accepted issue at edge N is visible on `locks_o`, `blocking_o` and `mem_busy_o` after edge N.
  - A writeback at edge N clears the lock after edge N if the count reaches 0.
- `issue_ready_o` is combinational from `issue_rd_i` and registered state only; no path from `wb_*`.

## Structure
- Package `maverickOne_pkg` holds `NUM_WB`, `LOCK_CNT_W` and typedef `lock_cnt_t` (`logic [LOCK_CNT_W-1:0]`).
- Package `maverickOne_pkg` also holds the FSM enum `lock_state_e` {NORMAL, BLOCKED}.
- Sub-module `reg_lock_cnt`:
  - One instance per register (generate loop; index 0 tied off).
  - Inputs: inc, dec count (0..NW).
  - Outputs: saturating counter, nonzero flag, underflow flag.

## Test plan
- Reset, then issue rd=5 -> `locks_o[5]`=1 next cycle; wb port0 rd=5 -> `locks_o[5]`=0 next cycle; `err_o`=0.
- Issue rd=7 three times (CW=2) -> `cnt`=3, `issue_ready_o`=0 for rd=7. A 4th issue is ignored and `err_o`=1. Three wb on rd=7 -> lock clears.
- Same-cycle issue rd=9 and wb rd=9 with `cnt`=1 -> `cnt` stays 1, lock held. Two wb ports rd=9 with `cnt`=2 -> lock clears in one cycle.
- Blocking issue -> `locks_o` all ones and `blocking_o`=1. Issues ignored with `issue_ready_o`=0. `blk_done_i` -> `locks_o` returns to counter-based value.
- Mem-op issue -> `mem_busy_o`=1. `mem_done_i` together with a new mem-op issue -> stays 1. `mem_done_i` alone -> 0.
- Issue rd=0 and wb rd=0 -> `locks_o[0]`=0, no error. Assert `arst_i` mid-lock -> all outputs 0 immediately.

Source files
------------

// File: rtl/reg_lock_tracker_pkg.sv
// Shared sizing constants, counter type and lock-tracker FSM encoding.
package maverickOne_pkg;

    localparam int NUM_REGS   = 32;
    localparam int NUM_WB     = 2;
    localparam int LOCK_CNT_W = 2;

    typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        BLOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/reg_lock_cnt.sv
// Per-register in-flight writer counter. One issue increment and up to NW
// writeback decrements are folded into a single net delta each cycle.
module reg_lock_cnt
    import maverickOne_pkg::*;
#(
    parameter int NW = NUM_WB,
    parameter int CW = LOCK_CNT_W,
    parameter int DW = $clog2(NW + 1)
) (
    input  logic          clk_i,
    input  logic          arst_i,
    input  logic          inc_i,
    input  logic [DW-1:0] dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          nz_next_o,
    output logic          uflow_o
);

    // One spare bit so cnt + 1 never wraps before the compare
    localparam int SW = ((CW > DW) ? CW : DW) + 1;
    localparam logic [SW-1:0] MAX_EXT = SW'((1 << CW) - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [SW-1:0] up;
    logic [SW-1:0] dn;

    // Net delta with clamping: floor at 0 (flagged), ceiling at full scale
    always_comb begin
        up      = SW'(cnt_q) + SW'(inc_i);
        dn      = SW'(dec_i);
        uflow_o = 1'b0;
        cnt_d   = cnt_q;
        if (dn > up) begin
            uflow_o = 1'b1;
            cnt_d   = '0;
        end else if ((up - dn) > MAX_EXT) begin
            cnt_d = CW'(MAX_EXT);
        end else begin
            cnt_d = CW'(up - dn);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign nz_next_o = (cnt_d != '0);

endmodule

// File: rtl/reg_lock_tracker.sv
// Architectural register lock state for the issue stage.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   NORMAL  | issues accepted unless the destination counter is full
//   BLOCKED | blocking instruction in flight; all regs locked, no issue
//
// Register 0 has no counter; it only reads as locked while BLOCKED.
module reg_lock_tracker
    import maverickOne_pkg::*;
#(
    parameter int NR = NUM_REGS,
    parameter int NW = NUM_WB,
    parameter int CW = LOCK_CNT_W
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     issue_valid_i,
    input  logic [$clog2(NR)-1:0]    issue_rd_i,
    input  logic                     issue_blocking_i,
    input  logic                     issue_mem_op_i,
    output logic                     issue_ready_o,
    input  logic [NW-1:0]            wb_valid_i,
    input  logic [NW*$clog2(NR)-1:0] wb_rd_i,
    input  logic                     blk_done_i,
    input  logic                     mem_done_i,
    output logic [NR-1:0]            locks_o,
    output logic                     blocking_o,
    output logic                     mem_busy_o,
    output logic                     err_o
);

    localparam int RW = $clog2(NR);
    localparam int DW = $clog2(NW + 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    lock_state_e   state_q;
    lock_state_e   state_d;
    logic [NR-1:0] locks_q;
    logic [NR-1:0] locks_d;
    logic          mem_busy_q;
    logic          mem_busy_d;
    logic          err_q;
    logic          err_d;

    logic          accept;
    logic          inc     [NR];
    logic [DW-1:0] dec     [NR];
    logic [CW-1:0] cnt     [NR];
    logic          nz_next [NR];
    logic          uflow   [NR];

    // Ready depends only on registered state and the requested rd
    assign issue_ready_o = (state_q == NORMAL) && (cnt[issue_rd_i] != CNT_MAX);
    assign accept        = issue_valid_i & issue_ready_o;

    // Route the accepted issue and matching writebacks to each counter
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            inc[i] = 1'b0;
            dec[i] = '0;
        end
        for (int i = 1; i < NR; i++) begin
            inc[i] = accept && (issue_rd_i == RW'(i));
            for (int p = 0; p < NW; p++) begin
                if (wb_valid_i[p] && (wb_rd_i[p*RW +: RW] == RW'(i))) begin
                    dec[i] = dec[i] + DW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_cnt
        if (g == 0) begin : g_zero
            assign cnt[g]     = '0;
            assign nz_next[g] = 1'b0;
            assign uflow[g]   = 1'b0;
        end else begin : g_reg
            reg_lock_cnt #(
                .NW (NW),
                .CW (CW),
                .DW (DW)
            ) u_cnt (
                .clk_i     (clk_i),
                .arst_i    (arst_i),
                .inc_i     (inc[g]),
                .dec_i     (dec[g]),
                .cnt_o     (cnt[g]),
                .nz_next_o (nz_next[g]),
                .uflow_o   (uflow[g])
            );
        end
    end

    // Next state, memory-busy, sticky error and next lock vector
    always_comb begin
        state_d    = state_q;
        mem_busy_d = mem_busy_q;
        err_d      = err_q;
        locks_d    = '0;

        case (state_q)
            NORMAL: begin
                if (accept && issue_blocking_i) begin
                    state_d = BLOCKED;
                end
                if (blk_done_i) begin
                    err_d = 1'b1;
                end
            end
            BLOCKED: begin
                if (blk_done_i) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase

        if (issue_valid_i && !issue_ready_o) begin
            err_d = 1'b1;
        end

        // A new memory op wins over a completion in the same cycle
        if (accept && issue_mem_op_i) begin
            mem_busy_d = 1'b1;
        end else if (mem_done_i) begin
            mem_busy_d = 1'b0;
        end

        for (int i = 0; i < NR; i++) begin
            if (uflow[i]) begin
                err_d = 1'b1;
            end
            locks_d[i] = nz_next[i] || (state_d == BLOCKED);
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= NORMAL;
            locks_q    <= '0;
            mem_busy_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            locks_q    <= locks_d;
            mem_busy_q <= mem_busy_d;
            err_q      <= err_d;
        end
    end

    assign locks_o    = locks_q;
    assign blocking_o = (state_q == BLOCKED);
    assign mem_busy_o = mem_busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Scoreboard bench for reg_lock_tracker: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_reg_lock_tracker;
    import maverickOne_pkg::*;

    localparam int NR = 32;
    localparam int NW = 2;
    localparam int RW = 5;
    localparam logic [NR-1:0] ALL = '1;

    logic            clk_i = 1'b0;
    logic            arst_i;
    logic            issue_valid_i;
    logic [RW-1:0]   issue_rd_i;
    logic            issue_blocking_i;
    logic            issue_mem_op_i;
    logic            issue_ready_o;
    logic [NW-1:0]   wb_valid_i;
    logic [NW*RW-1:0] wb_rd_i;
    logic            blk_done_i;
    logic            mem_done_i;
    logic [NR-1:0]   locks_o;
    logic            blocking_o;
    logic            mem_busy_o;
    logic            err_o;

    reg_lock_tracker #(.NR(NR), .NW(NW), .CW(2)) dut (
        .clk_i            (clk_i),
        .arst_i           (arst_i),
        .issue_valid_i    (issue_valid_i),
        .issue_rd_i       (issue_rd_i),
        .issue_blocking_i (issue_blocking_i),
        .issue_mem_op_i   (issue_mem_op_i),
        .issue_ready_o    (issue_ready_o),
        .wb_valid_i       (wb_valid_i),
        .wb_rd_i          (wb_rd_i),
        .blk_done_i       (blk_done_i),
        .mem_done_i       (mem_done_i),
        .locks_o          (locks_o),
        .blocking_o       (blocking_o),
        .mem_busy_o       (mem_busy_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        int            cyc;
        logic [NR-1:0] locks;
        logic          blk;
        logic          mb;
        logic          err;
        logic          rdy;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: compare every expectation due by this mid-cycle point
    always @(negedge clk_i) begin
        exp_t  e;
        string n;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (locks_o !== e.locks || blocking_o !== e.blk || mem_busy_o !== e.mb ||
                err_o !== e.err || issue_ready_o !== e.rdy) begin
                errors++;
                $display("FAIL %s: got locks=%h blk=%b mb=%b err=%b rdy=%b, want locks=%h blk=%b mb=%b err=%b rdy=%b",
                         n, locks_o, blocking_o, mem_busy_o, err_o, issue_ready_o,
                         e.locks, e.blk, e.mb, e.err, e.rdy);
            end
        end
    end

    function automatic logic [NR-1:0] bit_(input int n);
        logic [NR-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic drv(input logic iv, input logic [RW-1:0] rd, input logic blk,
                       input logic mo, input logic [NW-1:0] wv,
                       input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                       input logic bd, input logic md);
        issue_valid_i    = iv;
        issue_rd_i       = rd;
        issue_blocking_i = blk;
        issue_mem_op_i   = mo;
        wb_valid_i       = wv;
        wb_rd_i          = {r1, r0};
        blk_done_i       = bd;
        mem_done_i       = md;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic chk(input string n, input logic [NR-1:0] l, input logic b,
                       input logic m, input logic e, input logic r);
        sb_q.push_back(exp_t'{cyc, l, b, m, e, r});
        nm_q.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset behaviour; inputs ignored while held
        arst_i = 1'b1;
        drv(1, 3, 0, 1, 2'b01, 3, 0, 1, 0);
        chk("reset_state", '0, 0, 0, 0, 1);                    tick();
        chk("reset_ignores_inputs", '0, 0, 0, 0, 1);           tick();
        arst_i = 1'b0;

        // Basic lock / unlock on rd 5
        drv(1, 5, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("post_reset", '0, 0, 0, 0, 1);                     tick();
        drv(0, 0, 0, 0, 2'b01, 5, 0, 0, 0);
        chk("lock5_set", bit_(5), 0, 0, 0, 1);                 tick();

        // rd 0 issue and writeback: no lock, no error
        drv(1, 0, 0, 0, 2'b10, 0, 0, 0, 0);
        chk("lock5_clear", '0, 0, 0, 0, 1);                    tick();

        // Same-cycle issue+wb and dual writeback on rd 9
        drv(1, 9, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("rd0_no_lock", '0, 0, 0, 0, 1);                    tick();
        drv(1, 9, 0, 0, 2'b01, 9, 0, 0, 0);
        chk("lock9_set", bit_(9), 0, 0, 0, 1);                 tick();
        drv(1, 9, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("iss_wb9_held", bit_(9), 0, 0, 0, 1);              tick();
        drv(0, 0, 0, 0, 2'b11, 9, 9, 0, 0);
        chk("lock9_cnt2", bit_(9), 0, 0, 0, 1);                tick();

        // Memory busy set / set+clear / clear
        drv(1, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        chk("lock9_dual_wb_clear", '0, 0, 0, 0, 1);            tick();
        drv(1, 0, 0, 1, 2'b00, 0, 0, 0, 1);
        chk("mem_busy_set", '0, 0, 1, 0, 1);                   tick();
        drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        chk("mem_set_clear_same", '0, 0, 1, 0, 1);             tick();

        // Blocking issue, writeback while blocked, release
        drv(1, 2, 1, 0, 2'b00, 0, 0, 0, 0);
        chk("mem_done_clear", '0, 0, 0, 0, 1);                 tick();
        drv(0, 4, 0, 0, 2'b01, 2, 0, 0, 0);
        chk("blocked_all_locks", ALL, 1, 0, 0, 0);             tick();
        drv(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        chk("blocked_wb_keeps", ALL, 1, 0, 0, 0);              tick();

        // Saturate rd 7, overflow attempt, drain with 2+1 writebacks
        drv(1, 7, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("blk_done_release", '0, 0, 0, 0, 1);               tick();
        drv(1, 7, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("rd7_cnt1", bit_(7), 0, 0, 0, 1);                  tick();
        drv(1, 7, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("rd7_cnt2", bit_(7), 0, 0, 0, 1);                  tick();
        drv(1, 7, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("rd7_full_not_ready", bit_(7), 0, 0, 0, 0);        tick();
        drv(0, 0, 0, 0, 2'b11, 7, 7, 0, 0);
        chk("rd7_overflow_err", bit_(7), 0, 0, 1, 1);          tick();
        drv(0, 0, 0, 0, 2'b01, 7, 0, 0, 0);
        chk("rd7_after_dual_wb", bit_(7), 0, 0, 1, 1);         tick();

        // Issue while blocked is ignored
        drv(1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        chk("rd7_clear", '0, 0, 0, 1, 1);                      tick();
        drv(1, 4, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("blocked_again", ALL, 1, 0, 1, 0);                 tick();
        drv(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        chk("blocked_issue_ignored", ALL, 1, 0, 1, 0);         tick();

        // Reset mid-operation
        drv(1, 11, 0, 1, 2'b00, 0, 0, 0, 0);
        chk("release_no_stray_lock", '0, 0, 0, 1, 1);          tick();
        idle();
        chk("lock11_mem", bit_(11), 0, 1, 1, 1);               tick();
        arst_i = 1'b1;
        chk("rst_mid_op", '0, 0, 0, 0, 1);                     tick();
        arst_i = 1'b0;

        // Underflow sets error
        drv(0, 0, 0, 0, 2'b01, 6, 0, 0, 0);
        chk("after_mid_reset", '0, 0, 0, 0, 1);                tick();
        idle();
        chk("underflow_err", '0, 0, 0, 1, 1);                  tick();

        // blk_done in NORMAL sets error
        arst_i = 1'b1;
        chk("reset2", '0, 0, 0, 0, 1);                         tick();
        arst_i = 1'b0;
        drv(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        chk("reset2_release", '0, 0, 0, 0, 1);                 tick();
        idle();
        chk("blk_done_in_normal_err", '0, 0, 0, 1, 1);         tick();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
